multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The module SHALL have one clock and one reset: reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 opcode  input  7  opcode field of the latched instruction (IR[6:0]).
REQ-005 funct3  input  3  IR[14:12]; funct7  input  7  IR[31:25].
REQ-006 branch_taken  input  1  comparison result from the ALU, valid in EXEC.
REQ-007 imem_ready  input  1  instruction memory done, IR data valid this cycle.
REQ-008 dmem_ready  input  1  data memory access complete this cycle.
REQ-009 imem_req  output  1  instruction fetch request, held until imem_ready.
REQ-010 dmem_req  output  1  data request; dmem_we  output  1  write strobe, valid with dmem_req.
REQ-011 ir_we  output  1  IR load; pc_we  output  1  PC load; reg_we  output  1  register-file write.
REQ-012 pc_src  output  2  00 PC+4, 01 PC+imm, 10 (ALU result & ~1).
REQ-013 alu_a_sel  output  1  0 rs1, 1 PC; alu_b_sel  output  1  0 rs2, 1 imm.
REQ-014 alu_mode  output  2  00 ADD, 01 R-type decode, 10 I-type decode, 11 branch compare by funct3.
REQ-015 wb_sel  output  2  00 ALU, 01 load data, 10 PC+4, 11 imm.
REQ-016 state  output  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.
REQ-017 illegal  output  1  high while in TRAP.
REQ-018 instret  output  32  retired-instruction count (see Configuration).

Function
REQ-019 All outputs other than state/instret SHALL be Moore/Mealy combinational decodes of state, opcode, branch_taken and ready inputs; every strobe defaults to 0.
REQ-020 FETCH: imem_req=1; on imem_ready ir_we=1 for that cycle -> DECODE; else stay.
REQ-021 DECODE: if opcode not in {0110011, 0010011, 0000011, 1100111, 0100011, 1100011, 0110111, 0010111, 1101111} -> TRAP; else -> EXEC.
REQ-022 EXEC: R-type a=rs1,b=rs2,mode=01; I-imm a=rs1,b=imm,mode=10; load/store/JALR a=rs1,b=imm,mode=00; AUIPC a=PC,b=imm,mode=00; branch a=rs1,b=rs2,mode=11.
REQ-023 EXEC branch: pc_we=1, pc_src=01 if branch_taken else 00, -> FETCH (3-cycle instruction excl. fetch wait).
REQ-024 EXEC load/store -> MEM; all other legal opcodes -> WB.
REQ-025 MEM: dmem_req=1, dmem_we=1 for store only; stay until dmem_ready; load -> WB; store: pc_we=1, pc_src=00 in the dmem_ready cycle -> FETCH.
REQ-026 WB: reg_we=1, pc_we=1 for one cycle, -> FETCH; wb_sel: ALU for R/I-imm/AUIPC, load data for load, PC+4 for JAL/JALR, imm for LUI; pc_src 01 for JAL, 10 for JALR, 00 otherwise.
REQ-027 ALU select outputs SHALL be held at their EXEC values through MEM and WB for the same instruction.
REQ-028 imem_ready outside FETCH and dmem_ready outside MEM SHALL be ignored.
REQ-029 TRAP SHALL be absorbing: no strobes asserted, illegal=1, exit only via rst.
REQ-030 An instruction retires on the cycle pc_we=1; exactly one retirement per legal instruction.

Reset
REQ-031 rst asserted in any state SHALL immediately force state=FETCH and all strobes to 0, including mid-MEM with dmem_req high.
REQ-032 First cycle after rst deasserts SHALL assert imem_req; instret resets to 0.

Configuration
REQ-033 Macro INSTRET_COUNTER_EN defined: instret increments by 1 (mod 2^32, wraps 0xFFFFFFFF->0) each retirement cycle.
REQ-034 Macro INSTRET_COUNTER_EN undefined: no counter register; instret tied to 0.

Verification
REQ-035 ADD x3,x1,x2 (0x002081B3), imem_ready on 1st FETCH cycle -> states 0,1,2,4,0; reg_we=1 and pc_we=1 only in WB, wb_sel=00.
REQ-036 LW with dmem_ready delayed 3 cycles -> MEM held 4 cycles, dmem_we=0, then WB with wb_sel=01.
REQ-037 BEQ with branch_taken=1 then 0 -> pc_src=01 then 00, pc_we in EXEC, reg_we never asserted.
REQ-038 Opcode 0x73 (SYSTEM) -> DECODE then TRAP, illegal=1 held 10 cycles, no strobes; rst returns to FETCH.
REQ-039 rst pulsed during MEM of SW -> dmem_req drops same cycle, state=0, instret=0.
REQ-040 With INSTRET_COUNTER_EN, 5 legal instructions -> instret=5; preload 0xFFFFFFFF then retire one -> 0.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_controller
// Description : Control FSM for a multicycle RV32I-subset datapath.
//               FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH.
//               Unknown opcodes lock the FSM in TRAP until reset.
//               Optional retired-instruction counter enabled by the
//               macro INSTRET_COUNTER_EN (instret reads 0 otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_controller (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic        branch_taken,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        reg_we,
  output logic [1:0]  pc_src,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_mode,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic        illegal,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_IMM    = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;

  state_t r_state;

  logic w_is_r, w_is_imm, w_is_load, w_is_jalr, w_is_store;
  logic w_is_branch, w_is_lui, w_is_auipc, w_is_jal, w_legal;
  logic w_alu_a, w_alu_b;
  logic [1:0] w_alu_mode;

  // funct fields are decoded by the ALU itself, not by this controller
  logic w_unused_funct;
  assign w_unused_funct = ^{funct3, funct7};

  assign w_is_r      = (opcode == c_OP_R);
  assign w_is_imm    = (opcode == c_OP_IMM);
  assign w_is_load   = (opcode == c_OP_LOAD);
  assign w_is_jalr   = (opcode == c_OP_JALR);
  assign w_is_store  = (opcode == c_OP_STORE);
  assign w_is_branch = (opcode == c_OP_BRANCH);
  assign w_is_lui    = (opcode == c_OP_LUI);
  assign w_is_auipc  = (opcode == c_OP_AUIPC);
  assign w_is_jal    = (opcode == c_OP_JAL);
  assign w_legal     = w_is_r | w_is_imm | w_is_load | w_is_jalr | w_is_store |
                       w_is_branch | w_is_lui | w_is_auipc | w_is_jal;

  // State register; async reset returns to FETCH from anywhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:  if (imem_ready) r_state <= S_DECODE;
        S_DECODE: r_state <= w_legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          if (w_is_branch)                  r_state <= S_FETCH;
          else if (w_is_load || w_is_store) r_state <= S_MEM;
          else                              r_state <= S_WB;
        end
        S_MEM:    if (dmem_ready) r_state <= w_is_load ? S_WB : S_FETCH;
        S_WB:     r_state <= S_FETCH;
        S_TRAP:   r_state <= S_TRAP;
        default:  r_state <= S_FETCH;
      endcase
    end
  end

  // ALU operand/mode selection by instruction class; IR is stable from
  // DECODE onward, so these hold unchanged through MEM and WB
  always_comb begin
    w_alu_a    = 1'b0;
    w_alu_b    = 1'b0;
    w_alu_mode = 2'b00;
    if (w_is_r) begin
      w_alu_mode = 2'b01;
    end else if (w_is_imm) begin
      w_alu_b    = 1'b1;
      w_alu_mode = 2'b10;
    end else if (w_is_load || w_is_store || w_is_jalr) begin
      w_alu_b    = 1'b1;
    end else if (w_is_auipc) begin
      w_alu_a    = 1'b1;
      w_alu_b    = 1'b1;
    end else if (w_is_branch) begin
      w_alu_mode = 2'b11;
    end
  end

  // Output decode of state and inputs; reset masks every strobe at once
  always_comb begin
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    pc_we     = 1'b0;
    reg_we    = 1'b0;
    pc_src    = 2'b00;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_mode  = 2'b00;
    wb_sel    = 2'b00;
    illegal   = 1'b0;
    if (!rst) begin
      if (r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
        alu_a_sel = w_alu_a;
        alu_b_sel = w_alu_b;
        alu_mode  = w_alu_mode;
      end
      case (r_state)
        S_FETCH: begin
          imem_req = 1'b1;
          ir_we    = imem_ready;
        end
        S_EXEC: begin
          if (w_is_branch) begin
            pc_we  = 1'b1;
            pc_src = branch_taken ? 2'b01 : 2'b00;
          end
        end
        S_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = w_is_store;
          pc_we    = w_is_store & dmem_ready;
        end
        S_WB: begin
          reg_we = 1'b1;
          pc_we  = 1'b1;
          if (w_is_jal)       pc_src = 2'b01;
          else if (w_is_jalr) pc_src = 2'b10;
          if (w_is_load)                 wb_sel = 2'b01;
          else if (w_is_jal || w_is_jalr) wb_sel = 2'b10;
          else if (w_is_lui)             wb_sel = 2'b11;
        end
        S_TRAP:  illegal = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = r_state;

`ifdef INSTRET_COUNTER_EN
  logic [31:0] r_instret;

  // Count one retirement per PC update, wrapping at 2^32
  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_instret <= 32'd0;
    else if (pc_we) r_instret <= r_instret + 32'd1;
  end

  assign instret = r_instret;
`else
  assign instret = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_controller
// Description : Randomized self-checking bench for multicycle_controller.
//               Expected per-cycle outputs are derived from an
//               instruction-level model of the control sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        branch_taken, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we;
  logic [1:0]  pc_src, alu_mode, wb_sel;
  logic        alu_a_sel, alu_b_sel, illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_ret = 32'd0;
  logic [6:0]  legal_ops [9] = '{OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_STORE,
                                 OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL};

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
    .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we),
    .pc_we(pc_we), .reg_we(reg_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .alu_mode(alu_mode), .wb_sel(wb_sel), .state(state),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Packed output vector: state, imem_req, ir_we, dmem_req, dmem_we, pc_we,
  // reg_we, pc_src, {alu_a, alu_b, alu_mode}, wb_sel, illegal
  function automatic logic [17:0] V(input logic [2:0] st, input logic imr, input logic irw,
                                    input logic dr, input logic dw, input logic pw,
                                    input logic rw, input logic [1:0] ps,
                                    input logic [3:0] alu, input logic [1:0] ws,
                                    input logic ill);
    return {st, imr, irw, dr, dw, pw, rw, ps, alu, ws, ill};
  endfunction

  function automatic logic [17:0] obs_vec();
    return {state, imem_req, ir_we, dmem_req, dmem_we, pc_we, reg_we, pc_src,
            alu_a_sel, alu_b_sel, alu_mode, wb_sel, illegal};
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  // Operand table: {a_sel, b_sel, mode}
  function automatic logic [3:0] alu_cfg(input logic [6:0] op);
    case (op)
      OP_R:                       return 4'b0001;
      OP_IMM:                     return 4'b0110;
      OP_LOAD, OP_STORE, OP_JALR: return 4'b0100;
      OP_AUIPC:                   return 4'b1100;
      OP_BRANCH:                  return 4'b0011;
      default:                    return 4'b0000;
    endcase
  endfunction

  function automatic logic [1:0] wb_cfg(input logic [6:0] op);
    case (op)
      OP_LOAD:          return 2'b01;
      OP_JAL, OP_JALR:  return 2'b10;
      OP_LUI:           return 2'b11;
      default:          return 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] wb_pc(input logic [6:0] op);
    if (op == OP_JAL)  return 2'b01;
    if (op == OP_JALR) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [31:0] exp_instret();
`ifdef INSTRET_COUNTER_EN
    return exp_ret;
`else
    return 32'd0;
`endif
  endfunction

  // Drive one cycle of inputs, check outputs, optionally advance the clock
  task automatic step(input string tag, input logic imr, input logic dr, input logic bt,
                      input logic [17:0] exp, input bit adv);
    imem_ready   = imr;
    dmem_ready   = dr;
    branch_taken = bt;
    #1;
    chk(tag, {14'd0, obs_vec()}, {14'd0, exp});
    if (adv) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_out"}, {14'd0, obs_vec()}, 32'd0);
    chk({tag, "_instret"}, instret, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_ret = 32'd0;
  endtask

  // One instruction from fetch to retirement (or into TRAP)
  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input logic taken, input bit rst_in_mem);
    logic [3:0] a;
    logic       st;
    a  = alu_cfg(op);
    st = (op == OP_STORE);
    opcode = op;
    funct3 = 3'($urandom);
    funct7 = 7'($urandom);
    for (int i = 0; i < fw; i++)
      step("fetch_wait", 1'b0, r1(), r1(), V(3'd0,1,0,0,0,0,0,2'b00,4'h0,2'b00,0), 1'b1);
    step("fetch", 1'b1, r1(), r1(), V(3'd0,1,1,0,0,0,0,2'b00,4'h0,2'b00,0), 1'b1);
    step("decode", r1(), r1(), r1(), V(3'd1,0,0,0,0,0,0,2'b00,4'h0,2'b00,0), 1'b1);
    if (!is_legal(op)) begin
      for (int i = 0; i < 10; i++)
        step("trap", r1(), r1(), r1(), V(3'd5,0,0,0,0,0,0,2'b00,4'h0,2'b00,1), 1'b1);
      return;
    end
    if (op == OP_BRANCH) begin
      step("exec_branch", r1(), r1(), taken,
           V(3'd2,0,0,0,0,1,0,taken ? 2'b01 : 2'b00,a,2'b00,0), 1'b1);
      exp_ret++;
    end else if (op == OP_LOAD || op == OP_STORE) begin
      step("exec_mem", r1(), r1(), r1(), V(3'd2,0,0,0,0,0,0,2'b00,a,2'b00,0), 1'b1);
      if (rst_in_mem) begin
        step("mem_pre_rst", r1(), 1'b0, r1(), V(3'd3,0,0,1,st,0,0,2'b00,a,2'b00,0), 1'b0);
        do_reset("mem_rst");
        return;
      end
      for (int i = 0; i < mw; i++)
        step("mem_wait", r1(), 1'b0, r1(), V(3'd3,0,0,1,st,0,0,2'b00,a,2'b00,0), 1'b1);
      step("mem_done", r1(), 1'b1, r1(), V(3'd3,0,0,1,st,st,0,2'b00,a,2'b00,0), 1'b1);
      if (st) begin
        exp_ret++;
      end else begin
        step("wb_load", r1(), r1(), r1(), V(3'd4,0,0,0,0,1,1,2'b00,a,2'b01,0), 1'b1);
        exp_ret++;
      end
    end else begin
      step("exec", r1(), r1(), r1(), V(3'd2,0,0,0,0,0,0,2'b00,a,2'b00,0), 1'b1);
      step("wb", r1(), r1(), r1(), V(3'd4,0,0,0,0,1,1,wb_pc(op),a,wb_cfg(op),0), 1'b1);
      exp_ret++;
    end
    chk("instret", instret, exp_instret());
  endtask

  initial begin
    logic [6:0] op;
    rst = 1'b1;
    opcode = 7'd0; funct3 = 3'd0; funct7 = 7'd0;
    branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", {14'd0, obs_vec()}, 32'd0);
    chk("reset_instret", instret, 32'd0);
    rst = 1'b0;

    // Directed: ADD, delayed LW, BEQ taken/not, SYSTEM trap, reset mid-SW
    run_instr(OP_R, 0, 0, 1'b0, 1'b0);
    run_instr(OP_LOAD, 1, 3, 1'b0, 1'b0);
    run_instr(OP_BRANCH, 2, 0, 1'b1, 1'b0);
    run_instr(OP_BRANCH, 0, 0, 1'b0, 1'b0);
    run_instr(7'h73, 0, 0, 1'b0, 1'b0);
    do_reset("trap_rst");
    run_instr(OP_STORE, 0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++)
      run_instr(legal_ops[i], 0, 1, 1'b1, 1'b0);
    chk("five_retired", instret, exp_instret());

`ifdef INSTRET_COUNTER_EN
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    exp_ret = 32'hFFFF_FFFF;
    run_instr(OP_LUI, 0, 0, 1'b0, 1'b0);
    chk("instret_wrap", instret, 32'd0);
`endif

    // Random instruction stream with occasional illegal opcodes
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) op = 7'($urandom);
      else                            op = legal_ops[$urandom_range(0, 8)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), r1(), 1'b0);
      if (!is_legal(op)) do_reset("rand_trap_rst");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
